// File: rtl/jk_pkg.sv
// Shared types for the JK register/counter: operating modes and per-bit JK actions.
package jk_pkg;

   typedef enum logic [1:0] {
      MODE_JK   = 2'b00,
      MODE_UP   = 2'b01,
      MODE_DOWN = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ACT_HOLD = 2'b00,
      ACT_CLR  = 2'b01,
      ACT_SET  = 2'b10,
      ACT_TGL  = 2'b11
   } jk_act_e;

   // {j,k} maps directly onto the action encoding.
   function automatic jk_act_e jk_act(input logic j, input logic k);
      return jk_act_e'({j, k});
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK next-state logic; purely combinational, one instance per register bit.
module jk_cell
   import jk_pkg::*;
(
   input  logic j,
   input  logic k,
   input  logic q,
   output logic q_nxt
);

   always_comb begin
      q_nxt = q;
      case (jk_act(j, k))
         ACT_HOLD: q_nxt = q;
         ACT_CLR:  q_nxt = 1'b0;
         ACT_SET:  q_nxt = 1'b1;
         ACT_TGL:  q_nxt = ~q;
      endcase
   end

endmodule

// File: rtl/jk_reg_counter.sv
// JK register / up-down counter / loadable register, updated on the falling clk edge.
// Define JK_REG_COUNTER_SATURATE_EN to make counting saturate instead of wrapping.
module jk_reg_counter
   import jk_pkg::*;
#(
   parameter int              WIDTH = 8,
   parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             preset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   mode_e            m;
   logic [WIDTH-1:0] jk_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;
   logic             at_max;
   logic             at_zero;

   assign m       = mode_e'(mode);
   assign at_max  = (q == MAXV);
   assign at_zero = (q == '0);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .j     (j[i]),
         .k     (k[i]),
         .q     (q[i]),
         .q_nxt (jk_nxt[i])
      );
   end

   // tc looks only at mode and q, so it is valid even while en is low.
   always_comb begin
      tc = 1'b0;
      case (m)
         MODE_UP:   tc = at_max;
         MODE_DOWN: tc = at_zero;
         default:   tc = 1'b0;
      endcase
   end

   always_comb begin
      q_nxt    = q;
      wrap_nxt = 1'b0;
      if (preset) begin
         q_nxt = MAXV;
      end else if (en) begin
         case (m)
            MODE_JK:   q_nxt = (jk_nxt > MAXV) ? MAXV : jk_nxt;
            MODE_UP: begin
               if (at_max) begin
`ifdef JK_REG_COUNTER_SATURATE_EN
                  q_nxt    = q;
`else
                  q_nxt    = '0;
                  wrap_nxt = 1'b1;
`endif
               end else begin
                  q_nxt = q + ONE;
               end
            end
            MODE_DOWN: begin
               if (at_zero) begin
`ifdef JK_REG_COUNTER_SATURATE_EN
                  q_nxt    = q;
`else
                  q_nxt    = MAXV;
                  wrap_nxt = 1'b1;
`endif
               end else begin
                  q_nxt = q - ONE;
               end
            end
            MODE_LOAD: q_nxt = (d > MAXV) ? MAXV : d;
         endcase
      end
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         q    <= '0;
         wrap <= 1'b0;
      end else begin
         q    <= q_nxt;
         wrap <= wrap_nxt;
      end
   end

endmodule
